// File: rtl/dmem_wb_pkg.sv
// dmem_wb_pkg: shared FSM encoding, default sizes and entry type for the data-memory write buffer
package dmem_wb_pkg;
    localparam int DEPTH_D = 4;
    localparam int AW_D = 30;
    localparam int DW_D = 32;
    typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, GAP = 2'd2, READ = 2'd3} state_t;
    typedef struct packed {
        logic [AW_D-1:0] addr;
        logic [DW_D-1:0] data;
    } entry_t;
endpackage

// File: rtl/wb_fifo_cam.sv
// wb_fifo_cam: in-order store queue with a youngest-entry address match for load forwarding
module wb_fifo_cam
    import dmem_wb_pkg::*;
#(
    parameter int DEPTH = DEPTH_D,
    parameter int AW = AW_D,
    parameter int DW = DW_D,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    input  logic [AW-1:0] match_addr,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data,
    output logic [PW:0]   count,
    output logic          hit,
    output logic [DW-1:0] hit_data
);
    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head, tail, slot;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            head <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop) head <= head + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end

    always_ff @(posedge clk)
        if (push) begin
            addr_q[tail] <= push_addr;
            data_q[tail] <= push_data;
        end

    assign head_addr = addr_q[head];
    assign head_data = data_q[head];

    // walk oldest to youngest so the last valid match wins
    always_comb begin
        hit = 1'b0;
        hit_data = '0;
        slot = head;
        for (int i = 0; i < DEPTH; i++) begin
            if ((PW+1)'(i) < count && addr_q[slot] == match_addr) begin
                hit = 1'b1;
                hit_data = data_q[slot];
            end
            slot = slot + PW'(1);
        end
    end
endmodule

// File: rtl/dmem_write_buffer.sv
// dmem_write_buffer: posted store buffer between the core data port and the D-cache,
// draining stores in order as separate write pulses and forwarding buffered data to loads
module dmem_write_buffer
    import dmem_wb_pkg::*;
#(
    parameter int DEPTH = DEPTH_D,
    parameter int AW = AW_D,
    parameter int DW = DW_D
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    input  logic          core_wen,
    input  logic          core_ren,
    output logic [DW-1:0] core_rdata,
    output logic          core_stall,
    output logic [AW-1:0] dc_addr,
    output logic [DW-1:0] dc_wdata,
    output logic          dc_wen,
    output logic          dc_ren,
    input  logic [DW-1:0] dc_rdata,
    input  logic          dc_stall,
    output logic          buf_empty
);
    localparam int PW = $clog2(DEPTH);

    state_t state, state_d;
    logic [PW:0] count;
    logic [AW-1:0] head_addr, dc_addr_d;
    logic [DW-1:0] head_data, hit_data, dc_wdata_d;
    logic hit, full, push, pop, load, miss, rd_done, start_wr;

    wb_fifo_cam #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(pop),
        .push_addr(core_addr),
        .push_data(core_wdata),
        .match_addr(core_addr),
        .head_addr(head_addr),
        .head_data(head_data),
        .count(count),
        .hit(hit),
        .hit_data(hit_data)
    );

    // a simultaneous store and load is resolved as a store
    assign full = count == (PW+1)'(DEPTH);
    assign push = core_wen && !full;
    assign load = core_ren && !core_wen;
    assign miss = load && !hit;
    assign rd_done = state == READ && !dc_stall;
    assign pop = state == WRITE && !dc_stall;
    assign core_stall = (core_wen && full) || (miss && !rd_done);
    assign core_rdata = (load && hit) ? hit_data : (miss && rd_done) ? dc_rdata : '0;
    assign buf_empty = count == '0 && state != WRITE;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            dc_addr <= '0;
            dc_wdata <= '0;
            dc_wen <= 1'b0;
            dc_ren <= 1'b0;
        end else begin
            state <= state_d;
            dc_addr <= dc_addr_d;
            dc_wdata <= dc_wdata_d;
            dc_wen <= state_d == WRITE;
            dc_ren <= state_d == READ;
        end

    // loads take priority over draining; GAP forces a low cycle between write pulses
    always_comb begin
        state_d = state;
        case (state)
            IDLE:  state_d = miss ? READ : (count != '0) ? WRITE : IDLE;
            WRITE: state_d = dc_stall ? WRITE : GAP;
            GAP:   state_d = IDLE;
            READ:  state_d = dc_stall ? READ : IDLE;
        endcase
    end

    always_comb begin
        start_wr = state == IDLE && state_d == WRITE;
        dc_addr_d = (state_d == READ) ? core_addr : start_wr ? head_addr : dc_addr;
        dc_wdata_d = start_wr ? head_data : dc_wdata;
    end

    a_no_wen_ren: assert property (@(posedge clk) disable iff (!rst) !(core_wen && core_ren))
        else $error("core_wen and core_ren asserted together");
endmodule

// File: tb/tb_dmem_write_buffer.sv
// tb_dmem_write_buffer: directed stimulus checked every cycle against a queue model of pending stores
module tb_dmem_write_buffer;
    import dmem_wb_pkg::*;
    localparam int DEPTH = 4;
    localparam int AW = 30;
    localparam int DW = 32;

    typedef struct {
        bit            rd;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ev_t;

    logic clk = 1'b0, rst = 1'b0, core_wen = 1'b0, core_ren = 1'b0, dc_stall = 1'b0;
    logic [AW-1:0] core_addr = '0;
    logic [DW-1:0] core_wdata = '0, dc_rdata = 32'h9999_0009;
    logic [DW-1:0] core_rdata, dc_wdata;
    logic [AW-1:0] dc_addr;
    logic core_stall, dc_wen, dc_ren, buf_empty;

    entry_t pend[$];
    ev_t log_q[$], exp_q[$];
    int n_chk = 0, n_fail = 0;
    bit prev_done = 1'b0, h, acc;
    logic [DW-1:0] hd;

    dmem_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk),
        .rst(rst),
        .core_addr(core_addr),
        .core_wdata(core_wdata),
        .core_wen(core_wen),
        .core_ren(core_ren),
        .core_rdata(core_rdata),
        .core_stall(core_stall),
        .dc_addr(dc_addr),
        .dc_wdata(dc_wdata),
        .dc_wen(dc_wen),
        .dc_ren(dc_ren),
        .dc_rdata(dc_rdata),
        .dc_stall(dc_stall),
        .buf_empty(buf_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit st, input string name);
        core_wen = 1'b1;
        core_addr = a;
        core_wdata = d;
        @(negedge clk);
        chk(name, 64'(core_stall), 64'(st));
        step();
    endtask

    task automatic expw(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back('{1'b0, a, d});
    endtask

    task automatic expr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back('{1'b1, a, d});
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while (!(buf_empty && !dc_wen) && k < 50) begin
            step();
            k++;
        end
        chk(name, 64'(k < 50), 64'(1));
        repeat (3) step();
    endtask

    task automatic chk_log(input string name);
        chk({name, "_len"}, 64'(log_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            chk(name, 64'({log_q[i].rd, log_q[i].a, log_q[i].d}), 64'({exp_q[i].rd, exp_q[i].a, exp_q[i].d}));
        exp_q.delete();
        log_q.delete();
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_ctl"}, 64'({dc_wen, dc_ren, core_stall, buf_empty}), 64'(4'b0001));
        chk({name, "_dc"}, 64'({dc_addr, dc_wdata}), 64'(0));
        chk({name, "_rdata"}, 64'(core_rdata), 64'(0));
    endtask

    // per-cycle model: pending stores drain in order; loads see the youngest match
    always @(negedge clk) begin
        if (!rst) begin
            pend.delete();
            prev_done = 1'b0;
            chk_reset("in_reset");
        end else begin
            h = 1'b0;
            hd = '0;
            foreach (pend[i])
                if (pend[i].addr == core_addr) begin
                    h = 1'b1;
                    hd = pend[i].data;
                end
            chk("buf_empty", 64'(buf_empty), 64'(pend.size() == 0));
            if (core_wen)
                chk("store_stall", 64'(core_stall), 64'(pend.size() == DEPTH));
            else if (core_ren && h) begin
                chk("hit_stall", 64'(core_stall), 64'(0));
                chk("hit_data", 64'(core_rdata), 64'(hd));
            end else if (core_ren) begin
                chk("miss_stall", 64'(core_stall), 64'(!(dc_ren && !dc_stall)));
                if (dc_ren && !dc_stall) chk("miss_data", 64'(core_rdata), 64'(dc_rdata));
            end
            chk("wen_ren_excl", 64'(dc_wen && dc_ren), 64'(0));
            if (prev_done) chk("wen_gap", 64'(dc_wen), 64'(0));
            if (dc_ren) chk("ren_addr", 64'(dc_addr), 64'(core_addr));
            if (dc_wen) begin
                chk("wen_pending", 64'(pend.size() > 0), 64'(1));
                if (pend.size() > 0)
                    chk("wen_entry", 64'({dc_addr, dc_wdata}), 64'({pend[0].addr, pend[0].data}));
            end
            acc = core_wen && pend.size() < DEPTH;
            prev_done = dc_wen && !dc_stall;
            if (prev_done) begin
                log_q.push_back('{1'b0, dc_addr, dc_wdata});
                if (pend.size() > 0) void'(pend.pop_front());
            end
            if (dc_ren && !dc_stall) log_q.push_back('{1'b1, dc_addr, dc_rdata});
            if (acc) pend.push_back('{core_addr, core_wdata});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        repeat (3) step();
        chk_reset("reset_vals");
        rst = 1'b1;
        log_q.delete();
        repeat (10) step();
        chk("idle_no_wen", 64'(log_q.size()), 64'(0));
        chk("idle_empty", 64'({buf_empty, dc_wen, dc_ren}), 64'(3'b100));

        put(30'h0, 32'hFEFF_FFFF, 1'b0, "t2_store0");
        put(30'h1, 32'h0200_0000, 1'b0, "t2_store1");
        core_wen = 1'b0;
        wait_drain("t2_drain");
        expw(30'h0, 32'hFEFF_FFFF);
        expw(30'h1, 32'h0200_0000);
        chk_log("t2_order");

        dc_stall = 1'b1;
        for (int i = 0; i < 4; i++) put(30'h10 + 30'(i), 32'h100 + 32'(i), 1'b0, "t3_accept");
        core_wen = 1'b1;
        core_addr = 30'h14;
        core_wdata = 32'h104;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("t3_full_stall", 64'(core_stall), 64'(1));
            step();
        end
        dc_stall = 1'b0;
        @(negedge clk);
        chk("t3_pop_cycle_stall", 64'(core_stall), 64'(1));
        step();
        @(negedge clk);
        chk("t3_released", 64'(core_stall), 64'(0));
        step();
        core_wen = 1'b0;
        wait_drain("t3_drain");
        for (int i = 0; i < 5; i++) expw(30'h10 + 30'(i), 32'h100 + 32'(i));
        chk_log("t3_order");

        dc_stall = 1'b1;
        put(30'h5, 32'h11, 1'b0, "t4_store_a");
        put(30'h5, 32'h22, 1'b0, "t4_store_b");
        core_wen = 1'b0;
        core_ren = 1'b1;
        @(negedge clk);
        chk("t4_fwd_data", 64'(core_rdata), 64'(32'h22));
        chk("t4_fwd_stall", 64'({core_stall, dc_ren}), 64'(0));
        step();
        core_ren = 1'b0;
        dc_stall = 1'b0;
        wait_drain("t4_drain");
        expw(30'h5, 32'h11);
        expw(30'h5, 32'h22);
        chk_log("t4_order");

        dc_stall = 1'b1;
        put(30'hA, 32'hAA, 1'b0, "t5_store_a");
        put(30'hB, 32'hBB, 1'b0, "t5_store_b");
        core_wen = 1'b0;
        core_ren = 1'b1;
        core_addr = 30'h9;
        repeat (3) begin
            @(negedge clk);
            chk("t5_miss_held", 64'(core_stall), 64'(1));
            step();
        end
        dc_stall = 1'b0;
        k = 0;
        @(negedge clk);
        while (core_stall && k < 20) begin
            step();
            @(negedge clk);
            k++;
        end
        chk("t5_read_timeout", 64'(k < 20), 64'(1));
        chk("t5_read_data", 64'(core_rdata), 64'(32'h9999_0009));
        chk("t5_read_addr", 64'({dc_ren, dc_addr}), 64'({1'b1, 30'h9}));
        step();
        core_ren = 1'b0;
        wait_drain("t5_drain");
        expw(30'hA, 32'hAA);
        expr(30'h9, 32'h9999_0009);
        expw(30'hB, 32'hBB);
        chk_log("t5_order");

        dc_stall = 1'b1;
        for (int i = 0; i < 3; i++) put(30'h20 + 30'(i), 32'h200 + 32'(i), 1'b0, "t6_accept");
        core_wen = 1'b0;
        @(negedge clk);
        chk("t6_in_write", 64'({dc_wen, dc_addr}), 64'({1'b1, 30'h20}));
        step();
        rst = 1'b0;
        #1;
        chk_reset("t6_async_reset");
        repeat (2) step();
        rst = 1'b1;
        dc_stall = 1'b0;
        repeat (15) step();
        chk("t6_no_writes", 64'(log_q.size()), 64'(0));
        chk("t6_empty", 64'({buf_empty, dc_wen}), 64'(2'b10));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
